alu_result_display: RTL and testbench
=====================================

Name: alu_result_display

Overview:
- Downstream stage of the shifter+ALU datapath on the Basys board.
- Registers the 5-bit ALU Result and the 4-bit ALUFlags {N,Z,C,V} on a capture edge.
- Drives the flags onto LEDs.
- Time-multiplexes the captured value onto the 4-digit active-low seven-segment display, in hex or signed decimal.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit (1 ms at 100 MHz). Legal range is 2 or more. Benches use 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- capture  input  1  debounced button level; a 0->1 transition requests a capture
- hold  input  1  1 = ignore capture requests (display frozen)
- signed_mode  input  1  0 = unsigned hex view, 1 = two's-complement decimal view
- result  input  5  ALU Result
- flags  input  4  ALUFlags {N,Z,C,V}
- result_valid  output  1  1 once at least one capture has occurred since reset
- led  output  4  registered flags {N,Z,C,V}
- an  output  4  digit anodes, active low, an[0] = rightmost
- seg  output  7  {g,f,e,d,c,b,a}, active low
- dp  output  1  decimal point, active low; constant 1

Behaviour:
- Reset values:
  - result_q = 0, flags_q = 0, led = 0, result_valid = 0
  - capture_prev = 1, so a button held through reset produces no capture
  - refresh counter = 0, digit index = 0
  - an = 4'b1111, seg = 7'b1111111, dp = 1
  - Reset wins over every simultaneous event.
- Capture edge detection:
  - capture_prev <= capture every cycle, including while hold = 1.
  - A capture fires in cycle n when capture = 1, capture_prev = 0 and hold = 0.
  - At edge n: result_q <= result, flags_q <= flags, result_valid <= 1.
  - led and the display reflect the new value from cycle n+1 (1-cycle latency).
  - Level held high gives exactly one capture.
  - Releasing hold while capture is still high gives no capture.
- Refresh scan:
  - Counter runs 0..REFRESH_DIV-1 and wraps.
  - On wrap, the 2-bit digit index increments 0->1->2->3->0.
  - Scanning runs regardless of result_valid.
- Anodes:
  - result_valid = 1: an = ~(1 << index), i.e. 1110, 1101, 1011, 0111.
  - result_valid = 0: an = 4'b1111.
  - an and seg are registered together, so they always change in the same cycle with no ghosting.
- Digit content, unsigned view (signed_mode = 0):
  - d0 = hex of result_q[3:0]
  - d1 = hex of result_q[4] ('0' or '1')
  - d2 = blank, d3 = blank
- Digit content, signed view (signed_mode = 1):
  - mag = |result_q| as 5-bit two's complement; range 0..16 (-16 gives 16).
  - d3 = '-' if result_q[4] = 1, else blank.
  - d2 = blank.
  - d1 = tens of mag; blank when tens = 0 (leading-zero suppression).
  - d0 = units of mag.
  - Decimal conversion is combinational (compare/subtract 10); no divider.
- signed_mode is not latched; toggling it changes the view from the next scan register update without recapture.
- Segment codes {g..a}:
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Letters: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Symbols: '-'=0111111, blank=1111111
- Reset mid-scan returns to index 0, with the display dark until the next capture.

Test Plan:
- Reset released while capture = 1, then held high for 20 cycles -> result_valid stays 0, an = 1111, led = 0000.
- REFRESH_DIV = 4, signed_mode = 0, result = 5'b10110, flags = 4'b1010, capture edge -> next cycle led = 1010 and result_valid = 1.
  - Over 16 cycles: an = 1110 with seg = 0000010 ('6'); an = 1101 with seg = 1111001 ('1'); an = 1011 and an = 0111 with seg = 1111111. Each digit lit for exactly 4 cycles.
- Same stored value, toggle signed_mode = 1 without capture (-10) -> d3 = 0111111, d1 = 1111001, d0 = 1000000.
- Boundary values, signed_mode = 1:
  - result = 5'b10000 (-16) -> '-', '1', '6'.
  - result = 5'b00000 -> d1 blank, d0 = 1000000.
  - result = 5'b01111 (15) -> d3 blank, '1', '5'.
- hold = 1 with a capture edge presenting result = 5'b00011 -> result_q unchanged. Release hold while capture is still high -> still no capture. A fresh 0->1 edge -> '3' shown.
- Reset asserted in the same cycle as a capture edge -> result_valid = 0, led = 0000, an = 1111, index = 0 on the next cycle.

Source files
------------

// File: rtl/alu_result_display.sv
// ALU result display stage: captures the ALU Result and flags on a button
// edge, shows the flags on LEDs and scans the captured value across a
// 4-digit active-low seven-segment display in hex or signed decimal.
module alu_result_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       capture,
    input  logic       hold,
    input  logic       signed_mode,
    input  logic [4:0] result,
    input  logic [3:0] flags,
    output logic       result_valid,
    output logic [3:0] led,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Internal symbol codes: 0..15 are hex digits, plus dash and blank
    localparam logic [4:0] SYM_DASH  = 5'd16;
    localparam logic [4:0] SYM_BLANK = 5'd17;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    logic             capture_prev;
    logic [4:0]       result_q;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;

    logic             cap_fire;
    logic [4:0]       result_d;
    logic [3:0]       flags_d;
    logic             valid_d;
    logic [CNT_W-1:0] refresh_cnt_d;
    logic [1:0]       digit_idx_d;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;

    // Symbol code to active-low {g,f,e,d,c,b,a} pattern
    function automatic logic [6:0] sym_to_seg(input logic [4:0] sym);
        logic [6:0] s;
        case (sym)
            5'd0:    s = 7'b1000000;
            5'd1:    s = 7'b1111001;
            5'd2:    s = 7'b0100100;
            5'd3:    s = 7'b0110000;
            5'd4:    s = 7'b0011001;
            5'd5:    s = 7'b0010010;
            5'd6:    s = 7'b0000010;
            5'd7:    s = 7'b1111000;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0010000;
            5'd10:   s = 7'b0001000;
            5'd11:   s = 7'b0000011;
            5'd12:   s = 7'b1000110;
            5'd13:   s = 7'b0100001;
            5'd14:   s = 7'b0000110;
            5'd15:   s = 7'b0001110;
            5'd16:   s = 7'b0111111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Symbol shown on digit idx; signed view uses compare/subtract-10 decimal
    function automatic logic [4:0] digit_sym(input logic [1:0] idx,
                                             input logic [4:0] value,
                                             input logic       signed_view);
        logic signed [4:0] sval;
        logic [4:0]        mag;
        logic              tens;
        logic [3:0]        units;
        logic [4:0]        sym;
        sval  = value;
        // -16 negates to itself; read as unsigned that is the magnitude 16
        mag   = (sval < 0) ? 5'(-sval) : 5'(sval);
        tens  = (mag >= 5'd10);
        units = tens ? 4'(mag - 5'd10) : mag[3:0];
        sym   = SYM_BLANK;
        if (!signed_view) begin
            case (idx)
                2'd0:    sym = {1'b0, value[3:0]};
                2'd1:    sym = {4'b0000, value[4]};
                default: sym = SYM_BLANK;
            endcase
        end else begin
            case (idx)
                2'd0:    sym = {1'b0, units};
                2'd1:    sym = tens ? 5'd1 : SYM_BLANK;
                2'd2:    sym = SYM_BLANK;
                default: sym = value[4] ? SYM_DASH : SYM_BLANK;
            endcase
        end
        return sym;
    endfunction

    // Next-state logic; an/seg are computed from next-state values so the
    // display follows a capture one cycle later and stays aligned with digit_idx
    always_comb begin
        cap_fire      = capture && !capture_prev && !hold;
        result_d      = cap_fire ? result : result_q;
        flags_d       = cap_fire ? flags : led;
        valid_d       = result_valid || cap_fire;
        refresh_cnt_d = refresh_cnt + 1'b1;
        digit_idx_d   = digit_idx;
        if (refresh_cnt == CNT_LAST) begin
            refresh_cnt_d = '0;
            digit_idx_d   = digit_idx + 2'd1;
        end
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (valid_d) begin
            an_d  = ~(4'b0001 << digit_idx_d);
            seg_d = sym_to_seg(digit_sym(digit_idx_d, result_d, signed_mode));
        end
    end

    // State registers; reset dominates every simultaneous event
    always_ff @(posedge clk) begin
        if (reset) begin
            capture_prev <= 1'b1;
            result_q     <= '0;
            led          <= '0;
            result_valid <= 1'b0;
            refresh_cnt  <= '0;
            digit_idx    <= '0;
            an           <= AN_OFF;
            seg          <= SEG_BLANK;
        end else begin
            capture_prev <= capture;
            result_q     <= result_d;
            led          <= flags_d;
            result_valid <= valid_d;
            refresh_cnt  <= refresh_cnt_d;
            digit_idx    <= digit_idx_d;
            an           <= an_d;
            seg          <= seg_d;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with a 4-cycle refresh divider.
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       capture;
    logic       hold;
    logic       signed_mode;
    logic [4:0] result;
    logic [3:0] flags;
    logic       result_valid;
    logic [3:0] led;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_3   = 7'b0110000;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_6   = 7'b0000010;
    localparam logic [6:0] S_B   = 7'b0000011;
    localparam logic [6:0] S_DSH = 7'b0111111;
    localparam logic [6:0] S_BLK = 7'b1111111;

    alu_result_display #(.REFRESH_DIV(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .capture      (capture),
        .hold         (hold),
        .signed_mode  (signed_mode),
        .result       (result),
        .flags        (flags),
        .result_valid (result_valid),
        .led          (led),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Align to the first cycle of digit 0 and check one full 16-cycle scan
    task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [3:0] prev;
        logic       found;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
            else prev = an;
        end
        check({tag, "_sync"}, 8'(found), 8'd1);
        if (found) begin
            for (int k = 0; k < 16; k++) begin
                case (k / 4)
                    0:       begin exp_an = 4'b1110; exp_seg = e0; end
                    1:       begin exp_an = 4'b1101; exp_seg = e1; end
                    2:       begin exp_an = 4'b1011; exp_seg = e2; end
                    default: begin exp_an = 4'b0111; exp_seg = e3; end
                endcase
                check({tag, "_an"}, 8'(an), 8'(exp_an));
                check({tag, "_seg"}, 8'(seg), 8'(exp_seg));
                tick();
            end
        end
    endtask

    task automatic do_capture(input string tag, input logic [4:0] res, input logic [3:0] fl);
        capture = 1'b0;
        tick();
        result  = res;
        flags   = fl;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        check({tag, "_led"}, 8'(led), 8'(fl));
        check({tag, "_valid"}, 8'(result_valid), 8'd1);
    endtask

    initial begin
        reset       = 1'b1;
        capture     = 1'b1;
        hold        = 1'b0;
        signed_mode = 1'b0;
        result      = 5'd0;
        flags       = 4'd0;
        repeat (3) tick();
        check("reset_valid", 8'(result_valid), 8'd0);
        check("reset_an", 8'(an), 8'(4'b1111));
        check("reset_seg", 8'(seg), 8'(S_BLK));
        check("reset_dp", 8'(dp), 8'd1);

        // Button held through reset must not capture
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("held_valid", 8'(result_valid), 8'd0);
            check("held_an", 8'(an), 8'(4'b1111));
            check("held_led", 8'(led), 8'd0);
        end

        // Unsigned hex view of 5'b10110
        do_capture("cap_hex", 5'b10110, 4'b1010);
        scan_check("hex_16", S_6, S_1, S_BLK, S_BLK);

        // Same value in signed view: -10
        signed_mode = 1'b1;
        scan_check("dec_m10", S_0, S_1, S_BLK, S_DSH);

        do_capture("cap_m16", 5'b10000, 4'b1001);
        scan_check("dec_m16", S_6, S_1, S_BLK, S_DSH);
        do_capture("cap_zero", 5'b00000, 4'b0100);
        scan_check("dec_zero", S_0, S_BLK, S_BLK, S_BLK);
        do_capture("cap_15", 5'b01111, 4'b0010);
        scan_check("dec_15", S_5, S_1, S_BLK, S_BLK);

        // Hold blocks the edge; releasing hold with capture high does nothing
        hold    = 1'b1;
        capture = 1'b0;
        tick();
        result  = 5'b00011;
        flags   = 4'b0101;
        capture = 1'b1;
        tick();
        tick();
        check("hold_led", 8'(led), 8'(4'b0010));
        hold = 1'b0;
        tick();
        tick();
        check("release_led", 8'(led), 8'(4'b0010));
        scan_check("hold_15", S_5, S_1, S_BLK, S_BLK);
        capture = 1'b0;
        tick();
        capture = 1'b1;
        tick();
        check("fresh_led", 8'(led), 8'(4'b0101));
        capture = 1'b0;
        scan_check("dec_3", S_3, S_BLK, S_BLK, S_BLK);

        // Unsigned letter digit
        signed_mode = 1'b0;
        do_capture("cap_b", 5'b01011, 4'b1100);
        scan_check("hex_0b", S_B, S_0, S_BLK, S_BLK);

        // Reset coincident with a capture edge
        capture = 1'b0;
        tick();
        reset   = 1'b1;
        capture = 1'b1;
        result  = 5'b00111;
        flags   = 4'b1111;
        tick();
        check("rstcap_valid", 8'(result_valid), 8'd0);
        check("rstcap_led", 8'(led), 8'd0);
        check("rstcap_an", 8'(an), 8'(4'b1111));
        check("rstcap_seg", 8'(seg), 8'(S_BLK));
        check("rstcap_idx", 8'(dut.digit_idx), 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_valid", 8'(result_valid), 8'd0);
            check("post_rst_an", 8'(an), 8'(4'b1111));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
